if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 16-bit TSC pipelined CPU. It owns the PC, fetches from word-addressed instruction memory over a readM/inputReady handshake, and presents Instruction, PC and PC+1 to the decode-stage control unit. It honours load-use stalls, branch/jump redirects and HLT.

Parameters:
WORD_SIZE, 16, instruction/address/PC width
RESET_PC, 16'h0000, PC value after reset
BUBBLE_INST, 16'hF01C, instruction driven on the IF/ID output when the slot is invalid; the control unit treats the pair with IFID_Valid=0 as a bubble

Ports:
Clk  input  1  clock, all state on rising edge
Reset_N  input  1  reset, synchronous, active-low
Stall  input  1  hold PC and IF/ID (load-use hazard)
Redirect  input  1  taken branch/jump, single-cycle pulse
RedirectTarget  input  WORD_SIZE  new PC when Redirect=1
Halt  input  1  HLT reached in a later stage; stop fetching
readM  output  1  instruction memory read request
address  output  WORD_SIZE  instruction memory address
data  input  WORD_SIZE  instruction memory read data, valid when inputReady=1
inputReady  input  1  memory read completion, single-cycle pulse
IFID_Instruction  output  WORD_SIZE  fetched instruction to decode
IFID_PC  output  WORD_SIZE  PC of IFID_Instruction
IFID_NextPC  output  WORD_SIZE  IFID_PC+1, link value for JAL/JRL
IFID_Valid  output  1  IF/ID slot holds a real instruction
Halted  output  1  fetch permanently stopped

Behaviour:
- Reset (Reset_N=0 at an edge): PC=RESET_PC, state=IDLE, readM=0, address=RESET_PC, IFID_Instruction=BUBBLE_INST, IFID_PC=0, IFID_NextPC=0, IFID_Valid=0, Halted=0, squash=0, buffer empty. Reset mid-request abandons the request. A late inputReady is ignored while in IDLE.
- States:
  - IDLE: entered after reset. Goes to FETCH next cycle.
  - FETCH: readM=1 and address=PC, both held stable until inputReady.
  - BUFFERED: data has returned during a stall. readM=0.
  - HALT: terminal.
- FETCH, inputReady=1, no Stall/Redirect/squash:
  - IF/ID <= {data, PC, PC+1, Valid=1}.
  - PC <= PC+1 (wraps 16'hFFFF to 0).
  - New request issues the next cycle. Fetch-to-IF/ID latency is 1 edge after inputReady.
- FETCH, no inputReady, no Redirect: IF/ID gets Valid=0 and BUBBLE_INST unless Stall=1. When Stall=1 it holds.
- Stall=1 (no Redirect):
  - PC and IF/ID hold.
  - If inputReady arrives, data goes into the skid buffer, state goes to BUFFERED, readM=0.
  - In BUFFERED with Stall=0: IF/ID <= buffer (Valid=1), PC <= PC+1, state goes to FETCH.
- Redirect=1 (priority over Stall, same edge):
  - IF/ID flushed: Valid=0, BUBBLE_INST.
  - Buffer discarded.
  - If no request is outstanding, or inputReady is asserted in the same cycle: PC <= RedirectTarget, fetch restarts at the target next cycle, and that returned data is dropped.
  - If a request is outstanding without inputReady: record RedirectTarget in pending register, set squash=1, keep address stable. On the subsequent inputReady the data is dropped, PC <= pending, squash=0.
  - A second Redirect while squash=1 overwrites pending.
- Halt=1 (highest priority after reset):
  - Next edge: state=HALT, readM=0, IFID_Valid=0, Halted=1.
  - Returned data is ignored. Exit only by reset.
- IFID_NextPC is always registered as the PC of the captured instruction +1, modulo 2^16.
- No combinational path from Stall/Redirect to readM/address. All outputs are registered.

Decomposition:
- Shared opcodes.v: WORD_SIZE, BUBBLE_INST, state encodings (IDLE=2'd0, FETCH=2'd1, BUFFERED=2'd2, HALT=2'd3).
- One sub-module, ifid_register: IF/ID register with hold/flush/load controls. The fetch FSM, PC, squash/pending and skid buffer stay in if_fetch_stage.

Test Plan:
1. Reset, memory returns inputReady 2 cycles after readM with data 16'h6001, 16'h6102:
   - First request at address 0.
   - IF/ID shows {6001, PC 0, NextPC 1, Valid 1}, then {6102, 1, 2}.
   - No duplicate and no skipped PC.
2. Stall=1 for 3 cycles with inputReady arriving during the stall:
   - readM drops, IF/ID holds the old instruction.
   - After Stall=0 the buffered instruction appears with the correct PC, and the next fetch is PC+1.
3. Redirect with target 16'h0040 while a request to 16'h0005 is outstanding, inputReady 2 cycles later:
   - address stays 5 until inputReady, then the data is dropped.
   - Next request is at 16'h0040, IF/ID Valid=0 in between.
4. Redirect and Stall in the same cycle with target 16'h0010:
   - IF/ID flushed, fetch resumes at 16'h0010. The stall does not block the redirect.
5. PC at 16'hFFFF fetches 16'h9000:
   - IFID_NextPC=0 and the next address is 0.
6. Halt=1 mid-request, then Reset_N=0 for one cycle:
   - Halted=1, readM=0, Valid=0, later inputReady ignored.
   - After reset all outputs return to reset values and the first address is 0.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage of the 16-bit TSC pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_fetch_stage_pkg;

   localparam int          IF_WORD_SIZE   = 16;
   localparam logic [15:0] IF_RESET_PC    = 16'h0000;
   localparam logic [15:0] IF_BUBBLE_INST = 16'hF01C;

   // Fetch FSM encoding; values are shared with the rest of the codebase.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FETCH    = 2'd1,
      ST_BUFFERED = 2'd2,
      ST_HALT     = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_ifid_register.sv
// IF/ID pipeline register: holds the fetched instruction, its PC and PC+1.
// Latency: 1 edge from load to outputs.
// Backpressure: hold freezes the slot; flush beats load beats hold; otherwise a bubble is written.
//
// Ports: Clk, Reset_N (sync, active-low); flush/load/hold controls; load_inst/load_pc
// payload; IFID_Instruction/IFID_PC/IFID_NextPC/IFID_Valid registered outputs.
module if_fetch_stage_ifid_register #(
   parameter int                   WORD_SIZE   = 16,
   parameter logic [WORD_SIZE-1:0] BUBBLE_INST = 16'hF01C
)(
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic                 flush,
   input  logic                 load,
   input  logic                 hold,
   input  logic [WORD_SIZE-1:0] load_inst,
   input  logic [WORD_SIZE-1:0] load_pc,
   output logic [WORD_SIZE-1:0] IFID_Instruction,
   output logic [WORD_SIZE-1:0] IFID_PC,
   output logic [WORD_SIZE-1:0] IFID_NextPC,
   output logic                 IFID_Valid
);

   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         IFID_Instruction <= BUBBLE_INST;
         IFID_PC          <= '0;
         IFID_NextPC      <= '0;
         IFID_Valid       <= 1'b0;
      end else if (flush) begin
         IFID_Instruction <= BUBBLE_INST;
         IFID_Valid       <= 1'b0;
      end else if (load) begin
         IFID_Instruction <= load_inst;
         IFID_PC          <= load_pc;
         IFID_NextPC      <= load_pc + WORD_SIZE'(1);   // wraps modulo 2^WORD_SIZE
         IFID_Valid       <= 1'b1;
      end else if (!hold) begin
         // Nothing new arrived and decode is not stalled: present a bubble.
         IFID_Instruction <= BUBBLE_INST;
         IFID_Valid       <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory, feeds the IF/ID register.
// Latency: IF/ID loads on the edge where inputReady is seen; next request issues the following cycle.
// Backpressure: Stall holds PC and IF/ID; data returning during a stall is parked in a one-entry skid buffer.
//
// Ports: Clk, Reset_N (sync, active-low); Stall, Redirect/RedirectTarget, Halt from later
// stages; readM/address/data/inputReady memory handshake; IFID_* to decode; Halted status.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int                   WORD_SIZE   = IF_WORD_SIZE,
   parameter logic [WORD_SIZE-1:0] RESET_PC    = IF_RESET_PC,
   parameter logic [WORD_SIZE-1:0] BUBBLE_INST = IF_BUBBLE_INST
)(
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic                 Stall,
   input  logic                 Redirect,
   input  logic [WORD_SIZE-1:0] RedirectTarget,
   input  logic                 Halt,
   output logic                 readM,
   output logic [WORD_SIZE-1:0] address,
   input  logic [WORD_SIZE-1:0] data,
   input  logic                 inputReady,
   output logic [WORD_SIZE-1:0] IFID_Instruction,
   output logic [WORD_SIZE-1:0] IFID_PC,
   output logic [WORD_SIZE-1:0] IFID_NextPC,
   output logic                 IFID_Valid,
   output logic                 Halted
);

   fetch_state_t         state_q, state_d;
   logic [WORD_SIZE-1:0] pc_q, pc_d;
   logic [WORD_SIZE-1:0] pend_q, pend_d;    // redirect target waiting for the squashed request
   logic                 squash_q, squash_d;
   logic [WORD_SIZE-1:0] buf_q, buf_d;      // skid entry, valid exactly while in ST_BUFFERED
   logic                 readm_d;
   logic                 halted_d;

   logic                 ifid_flush, ifid_load, ifid_hold;
   logic [WORD_SIZE-1:0] ifid_inst;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      squash_d   = squash_q;
      buf_d      = buf_q;
      halted_d   = Halted;
      ifid_flush = 1'b0;
      ifid_load  = 1'b0;
      ifid_hold  = Stall;
      ifid_inst  = data;

      if (Halt || state_q == ST_HALT) begin
         state_d    = ST_HALT;
         squash_d   = 1'b0;
         halted_d   = 1'b1;
         ifid_flush = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_FETCH;
               if (Redirect) begin
                  pc_d       = RedirectTarget;
                  ifid_flush = 1'b1;
               end
            end

            ST_FETCH: begin
               if (Redirect) begin
                  ifid_flush = 1'b1;
                  if (inputReady) begin
                     // Returning data belongs to the wrong path; restart at the target now.
                     pc_d     = RedirectTarget;
                     squash_d = 1'b0;
                  end else begin
                     // The request must complete at its original address before we move on.
                     pend_d   = RedirectTarget;
                     squash_d = 1'b1;
                  end
               end else if (inputReady) begin
                  if (squash_q) begin
                     pc_d     = pend_q;
                     squash_d = 1'b0;
                  end else if (Stall) begin
                     buf_d   = data;
                     state_d = ST_BUFFERED;
                  end else begin
                     ifid_load = 1'b1;
                     pc_d      = pc_q + WORD_SIZE'(1);
                  end
               end
            end

            ST_BUFFERED: begin
               if (Redirect) begin
                  ifid_flush = 1'b1;
                  pc_d       = RedirectTarget;
                  state_d    = ST_FETCH;
               end else if (!Stall) begin
                  ifid_load = 1'b1;
                  ifid_inst = buf_q;
                  pc_d      = pc_q + WORD_SIZE'(1);
                  state_d   = ST_FETCH;
               end
            end

            default: begin
               state_d = ST_HALT;
            end
         endcase
      end

      // readM is decided from next state only, so Stall/Redirect never reach it combinationally.
      readm_d = (state_d == ST_FETCH);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         pend_q   <= '0;
         squash_q <= 1'b0;
         buf_q    <= '0;
         readM    <= 1'b0;
         Halted   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pend_q   <= pend_d;
         squash_q <= squash_d;
         buf_q    <= buf_d;
         readM    <= readm_d;
         Halted   <= halted_d;
      end
   end

   // The PC only changes when a request completes, so it doubles as the stable address.
   assign address = pc_q;

   if_fetch_stage_ifid_register #(
      .WORD_SIZE   (WORD_SIZE),
      .BUBBLE_INST (BUBBLE_INST)
   ) u_ifid (
      .Clk              (Clk),
      .Reset_N          (Reset_N),
      .flush            (ifid_flush),
      .load             (ifid_load),
      .hold             (ifid_hold),
      .load_inst        (ifid_inst),
      .load_pc          (pc_q),
      .IFID_Instruction (IFID_Instruction),
      .IFID_PC          (IFID_PC),
      .IFID_NextPC      (IFID_NextPC),
      .IFID_Valid       (IFID_Valid)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   localparam logic [15:0] BUBBLE = 16'hF01C;

   logic        Clk;
   logic        Reset_N;
   logic        Stall;
   logic        Redirect;
   logic [15:0] RedirectTarget;
   logic        Halt;
   logic        readM;
   logic [15:0] address;
   logic [15:0] data;
   logic        inputReady;
   logic [15:0] IFID_Instruction;
   logic [15:0] IFID_PC;
   logic [15:0] IFID_NextPC;
   logic        IFID_Valid;
   logic        Halted;

   if_fetch_stage dut (
      .Clk              (Clk),
      .Reset_N          (Reset_N),
      .Stall            (Stall),
      .Redirect         (Redirect),
      .RedirectTarget   (RedirectTarget),
      .Halt             (Halt),
      .readM            (readM),
      .address          (address),
      .data             (data),
      .inputReady       (inputReady),
      .IFID_Instruction (IFID_Instruction),
      .IFID_PC          (IFID_PC),
      .IFID_NextPC      (IFID_NextPC),
      .IFID_Valid       (IFID_Valid),
      .Halted           (Halted)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Memory model state
   bit          mem_busy = 0;
   int          mem_cnt  = 0;
   int          mem_lat  = 2;
   logic [15:0] mem_addr = 16'h0;
   int          ir_count = 0;

   // Reference model: the program stream decode should see
   logic [15:0] exp_pc    = 16'h0;
   bit          halted_m  = 0;
   int          delivered = 0;

   // Inputs applied at the last edge and outputs just before it
   logic        p_rst, p_stall, p_redir, p_halt;
   logic [15:0] p_tgt;
   logic [15:0] s_inst, s_pc, s_npc;
   logic        s_vld;

   function automatic logic [15:0] memf(input logic [15:0] a);
      if (a == 16'h0000) return 16'h6001;
      if (a == 16'h0001) return 16'h6102;
      if (a == 16'hFFFF) return 16'h9000;
      return (a * 16'd7) ^ 16'h3C5A;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_check();
      logic [15:0] npc_e;
      if (!p_rst) begin
         chk1("rst_readM", readM, 1'b0);
         chk ("rst_address", address, 16'h0000);
         chk ("rst_inst", IFID_Instruction, BUBBLE);
         chk ("rst_pc", IFID_PC, 16'h0000);
         chk ("rst_npc", IFID_NextPC, 16'h0000);
         chk1("rst_valid", IFID_Valid, 1'b0);
         chk1("rst_halted", Halted, 1'b0);
         exp_pc   = 16'h0000;
         halted_m = 0;
         mem_busy = 0;
      end else if (p_halt || halted_m) begin
         halted_m = 1;
         chk1("halt_halted", Halted, 1'b1);
         chk1("halt_readM", readM, 1'b0);
         chk1("halt_valid", IFID_Valid, 1'b0);
      end else begin
         chk1("halted_low", Halted, 1'b0);
         if (p_redir) begin
            chk1("flush_valid", IFID_Valid, 1'b0);
            chk ("flush_inst", IFID_Instruction, BUBBLE);
            exp_pc = p_tgt;
         end else if (p_stall) begin
            chk ("hold_inst", IFID_Instruction, s_inst);
            chk ("hold_pc", IFID_PC, s_pc);
            chk ("hold_npc", IFID_NextPC, s_npc);
            chk1("hold_valid", IFID_Valid, s_vld);
         end else if (IFID_Valid === 1'b1) begin
            npc_e = exp_pc + 16'd1;
            chk("sb_inst", IFID_Instruction, memf(exp_pc));
            chk("sb_pc", IFID_PC, exp_pc);
            chk("sb_npc", IFID_NextPC, npc_e);
            exp_pc = npc_e;
            delivered++;
         end else begin
            chk("bubble_inst", IFID_Instruction, BUBBLE);
         end
      end
   endtask

   // One clock: memory responds, the edge happens, outputs are checked 1 time unit later.
   task automatic cycle();
      bit started = 0;
      if (!mem_busy && readM === 1'b1) begin
         mem_busy = 1;
         mem_cnt  = mem_lat;
         mem_addr = address;
         started  = 1;
      end
      if (mem_busy && !started) chk("addr_stable", address, mem_addr);
      if (mem_busy && mem_cnt == 0) begin
         inputReady = 1'b1;
         data       = memf(mem_addr);
         mem_busy   = 0;
         ir_count++;
      end else begin
         inputReady = 1'b0;
         data       = 16'($urandom);
         if (mem_busy) mem_cnt--;
      end
      p_rst = Reset_N; p_stall = Stall; p_redir = Redirect; p_halt = Halt; p_tgt = RedirectTarget;
      s_inst = IFID_Instruction; s_pc = IFID_PC; s_npc = IFID_NextPC; s_vld = IFID_Valid;
      @(posedge Clk);
      #1;
      model_check();
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (IFID_Valid !== 1'b1 && n < 40);
      chk1(tag, IFID_Valid, 1'b1);
   endtask

   task automatic wait_req(input string tag, input logic [15:0] a, input bit any_addr);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!(readM === 1'b1 && mem_busy && mem_cnt >= 1 && (any_addr || address == a)) && n < 40);
      chk1(tag, readM === 1'b1 && mem_busy && (any_addr || address == a), 1'b1);
   endtask

   initial begin
      int ir0;
      int d0;
      Reset_N = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = 16'h0;
      Halt = 1'b0; inputReady = 1'b0; data = 16'h0;

      // 1: reset, then two sequential fetches with 2-cycle memory
      cycle(); cycle();
      Reset_N = 1'b1; mem_lat = 2;
      cycle();
      chk1("t1_readM", readM, 1'b1);
      chk ("t1_addr", address, 16'h0000);
      wait_valid("t1_v0");
      chk("t1_inst0", IFID_Instruction, 16'h6001);
      chk("t1_pc0", IFID_PC, 16'h0000);
      chk("t1_npc0", IFID_NextPC, 16'h0001);
      wait_valid("t1_v1");
      chk("t1_inst1", IFID_Instruction, 16'h6102);
      chk("t1_pc1", IFID_PC, 16'h0001);
      chk("t1_npc1", IFID_NextPC, 16'h0002);

      // 2: stall for 3 cycles while the fetch of PC 2 returns
      mem_lat = 1; Stall = 1'b1;
      cycle(); cycle(); cycle();
      chk1("t2_readM_low", readM, 1'b0);
      chk ("t2_hold_inst", IFID_Instruction, 16'h6102);
      chk ("t2_hold_pc", IFID_PC, 16'h0001);
      Stall = 1'b0;
      cycle();
      chk1("t2_buf_valid", IFID_Valid, 1'b1);
      chk ("t2_buf_pc", IFID_PC, 16'h0002);
      chk ("t2_buf_inst", IFID_Instruction, memf(16'h0002));
      chk ("t2_next_addr", address, 16'h0003);
      chk1("t2_readM", readM, 1'b1);

      // 3: redirect to 0x40 while a request to 5 is outstanding
      mem_lat = 2;
      Redirect = 1'b1; RedirectTarget = 16'h0005;
      cycle();
      Redirect = 1'b0;
      wait_req("t3_req5", 16'h0005, 1'b0);
      Redirect = 1'b1; RedirectTarget = 16'h0040;
      cycle();
      Redirect = 1'b0;
      chk ("t3_addr_hold", address, 16'h0005);
      chk1("t3_readM_hold", readM, 1'b1);
      cycle();
      chk1("t3_dropped", IFID_Valid, 1'b0);
      chk ("t3_new_addr", address, 16'h0040);
      wait_valid("t3_v");
      chk("t3_pc", IFID_PC, 16'h0040);

      // 4: redirect and stall together
      Stall = 1'b1; Redirect = 1'b1; RedirectTarget = 16'h0010;
      cycle();
      Stall = 1'b0; Redirect = 1'b0;
      chk1("t4_flush", IFID_Valid, 1'b0);
      wait_valid("t4_v");
      chk("t4_pc", IFID_PC, 16'h0010);
      chk("t4_inst", IFID_Instruction, memf(16'h0010));

      // 5: PC wrap at 0xFFFF
      Redirect = 1'b1; RedirectTarget = 16'hFFFF;
      cycle();
      Redirect = 1'b0;
      wait_valid("t5_v");
      chk("t5_inst", IFID_Instruction, 16'h9000);
      chk("t5_pc", IFID_PC, 16'hFFFF);
      chk("t5_npc", IFID_NextPC, 16'h0000);
      chk("t5_addr", address, 16'h0000);

      // 6: halt mid-request, late inputReady ignored, then reset
      wait_req("t6_req", 16'h0, 1'b1);
      Halt = 1'b1;
      cycle();
      Halt = 1'b0;
      ir0 = ir_count;
      d0  = delivered;
      repeat (4) cycle();
      chk1("t6_late_ir_seen", ir_count > ir0, 1'b1);
      chk1("t6_no_delivery", delivered == d0, 1'b1);
      Reset_N = 1'b0;
      cycle();
      Reset_N = 1'b1;
      cycle();
      chk1("t6_readM", readM, 1'b1);
      chk ("t6_addr", address, 16'h0000);

      // Random phase against the stream model
      d0 = delivered;
      for (int i = 0; i < 600; i++) begin
         Stall          = ($urandom_range(0, 99) < 30);
         Redirect       = ($urandom_range(0, 99) < 5);
         RedirectTarget = 16'($urandom);
         mem_lat        = $urandom_range(0, 3);
         cycle();
      end
      Stall = 1'b0; Redirect = 1'b0;
      cycle();
      chk1("rand_progress", (delivered - d0) > 40, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
